// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, runs one request/grant/response
// fetch at a time and buffers the result for decode behind a valid/ready pair.
module fetch_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] fetch_pc,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        discard_q, discard_d;
  logic        fault_q, fault_d;
  logic        misaligned;

  assign misaligned = redirect_valid && (redirect_addr[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;
    discard_d   = discard_q;
    fault_d     = fault_q;

    if (misaligned && state_q != StHalt) begin
      // Bad target wins over everything else; PC keeps its last legal value.
      fault_d = 1'b1;
      state_d = StHalt;
    end else begin
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (redirect_valid) begin
            pc_d = redirect_addr;
            if (imem_gnt) begin
              discard_d = 1'b1;
              state_d   = StWait;
            end
          end else if (imem_gnt) begin
            discard_d = 1'b0;
            state_d   = StWait;
          end
        end
        StWait: begin
          if (redirect_valid) begin
            pc_d      = redirect_addr;
            discard_d = 1'b1;
            if (imem_rvalid) state_d = StReq;
          end else if (imem_rvalid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = StReq;
            end else begin
              inst_data_d = imem_rdata;
              inst_pc_d   = pc_q;
              state_d     = StHold;
            end
          end
        end
        StHold: begin
          if (redirect_valid) begin
            pc_d    = redirect_addr;
            state_d = StReq;
          end else if (inst_ready) begin
            pc_d    = pc_q + 32'd4;
            state_d = StReq;
          end
        end
        StHalt: state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_ADDR;
      inst_data_q <= 32'h0;
      inst_pc_q   <= 32'h0;
      discard_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
      discard_q   <= discard_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_req    = (state_q == StReq);
  assign inst_valid  = (state_q == StHold);
  assign imem_addr   = pc_q;
  assign fetch_pc    = pc_q;
  assign inst_data   = inst_data_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Cycle-by-cycle directed vectors for fetch_sequencer, plus a wrap-around
// sequence on a second instance whose reset PC is 32'hFFFF_FFFC.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: RESET_ADDR = 0
  logic        reset, rv, gnt, rvalid, rdy;
  logic [31:0] raddr, rdata;
  logic        req, iv, fault;
  logic [31:0] addr, idata, ipc, fpc;

  // Instance 1: RESET_ADDR = FFFF_FFFC
  logic        reset1, rv1, gnt1, rvalid1, rdy1;
  logic [31:0] raddr1, rdata1;
  logic        req1, iv1, fault1;
  logic [31:0] addr1, idata1, ipc1, fpc1;

  fetch_sequencer #(.RESET_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset), .redirect_valid(rv), .redirect_addr(raddr),
    .imem_req(req), .imem_addr(addr), .imem_gnt(gnt), .imem_rvalid(rvalid),
    .imem_rdata(rdata), .inst_valid(iv), .inst_data(idata), .inst_pc(ipc),
    .inst_ready(rdy), .fetch_pc(fpc), .fetch_fault(fault)
  );

  fetch_sequencer #(.RESET_ADDR(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset1), .redirect_valid(rv1), .redirect_addr(raddr1),
    .imem_req(req1), .imem_addr(addr1), .imem_gnt(gnt1), .imem_rvalid(rvalid1),
    .imem_rdata(rdata1), .inst_valid(iv1), .inst_data(idata1), .inst_pc(ipc1),
    .inst_ready(rdy1), .fetch_pc(fpc1), .fetch_fault(fault1)
  );

  typedef struct {
    logic        rst, rv, gnt, rvalid, rdy;
    logic [31:0] raddr, rdata;
    logic        e_req, e_iv, e_fault;
    logic [31:0] e_addr, e_idata, e_ipc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  // Inputs applied this cycle, then outputs expected during this same cycle.
  task automatic v(input logic r, input logic rv_i, input logic [31:0] ra,
                   input logic g, input logic rval, input logic [31:0] rd,
                   input logic rdy_i, input logic e_req, input logic [31:0] e_addr,
                   input logic e_iv, input logic [31:0] e_idata,
                   input logic [31:0] e_ipc, input logic e_f);
    vec_t t;
    t.rst = r; t.rv = rv_i; t.raddr = ra; t.gnt = g; t.rvalid = rval;
    t.rdata = rd; t.rdy = rdy_i; t.e_req = e_req; t.e_addr = e_addr;
    t.e_iv = e_iv; t.e_idata = e_idata; t.e_ipc = e_ipc; t.e_fault = e_f;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    // rst rv raddr  gnt rvl rdata  rdy | req addr iv idata ipc flt
    v(0, 0, 0,     0, 0, 0,     0,  0, 32'h0,   0, 32'h0,  32'h0,   0); // 0 IDLE
    v(0, 0, 0,     1, 0, 0,     0,  1, 32'h0,   0, 32'h0,  32'h0,   0); // 1 REQ
    v(0, 0, 0,     0, 1, 32'hA0,0,  0, 32'h0,   0, 32'h0,  32'h0,   0); // 2 WAIT
    v(0, 0, 0,     0, 0, 0,     1,  0, 32'h0,   1, 32'hA0, 32'h0,   0); // 3 HOLD
    v(0, 0, 0,     1, 0, 0,     0,  1, 32'h4,   0, 32'hA0, 32'h0,   0); // 4 REQ
    v(0, 0, 0,     0, 1, 32'hA1,0,  0, 32'h4,   0, 32'hA0, 32'h0,   0); // 5 WAIT
    for (int i = 0; i < 5; i++)
      v(0, 0, 0,   0, 0, 0,     0,  0, 32'h4,   1, 32'hA1, 32'h4,   0); // 6-10 stall
    v(0, 0, 0,     0, 0, 0,     1,  0, 32'h4,   1, 32'hA1, 32'h4,   0); // 11 accept
    v(0, 1, 32'h100,1,0, 0,     0,  1, 32'h8,   0, 32'hA1, 32'h4,   0); // 12 redir+gnt
    v(0, 0, 0,     0, 1, 32'hA2,0,  0, 32'h100, 0, 32'hA1, 32'h4,   0); // 13 drop
    v(0, 0, 0,     1, 0, 0,     0,  1, 32'h100, 0, 32'hA1, 32'h4,   0); // 14 REQ
    v(0, 0, 0,     0, 1, 32'hB0,0,  0, 32'h100, 0, 32'hA1, 32'h4,   0); // 15 WAIT
    v(0, 1, 32'h40,0, 0, 0,     1,  0, 32'h100, 1, 32'hB0, 32'h100, 0); // 16 squash
    v(0, 0, 0,     1, 0, 0,     0,  1, 32'h40,  0, 32'hB0, 32'h100, 0); // 17 REQ
    v(0, 1, 32'h102,0,0, 0,     0,  0, 32'h40,  0, 32'hB0, 32'h100, 0); // 18 misalign
    v(0, 0, 0,     0, 1, 32'hC0,0,  0, 32'h40,  0, 32'hB0, 32'h100, 1); // 19 HALT
    v(0, 1, 32'h200,1,1, 32'hC1,1,  0, 32'h40,  0, 32'hB0, 32'h100, 1); // 20 ignored
    v(1, 1, 32'h300,1,1, 32'hC2,1,  0, 32'h40,  0, 32'hB0, 32'h100, 1); // 21 reset
    v(0, 0, 0,     0, 0, 0,     0,  0, 32'h0,   0, 32'h0,  32'h0,   0); // 22 IDLE
    v(0, 0, 0,     0, 0, 0,     0,  1, 32'h0,   0, 32'h0,  32'h0,   0); // 23 no gnt
    v(0, 0, 0,     1, 0, 0,     0,  1, 32'h0,   0, 32'h0,  32'h0,   0); // 24 gnt
    v(0, 0, 0,     0, 0, 0,     0,  0, 32'h0,   0, 32'h0,  32'h0,   0); // 25 WAIT
    v(0, 1, 32'h20,0, 0, 0,     0,  0, 32'h0,   0, 32'h0,  32'h0,   0); // 26 redir WAIT
    v(0, 0, 0,     0, 1, 32'hD0,0,  0, 32'h20,  0, 32'h0,  32'h0,   0); // 27 drop
    v(0, 1, 32'h30,0, 0, 0,     0,  1, 32'h20,  0, 32'h0,  32'h0,   0); // 28 redir REQ
    v(0, 0, 0,     1, 0, 0,     0,  1, 32'h30,  0, 32'h0,  32'h0,   0); // 29 gnt
    v(0, 0, 0,     0, 1, 32'hD1,0,  0, 32'h30,  0, 32'h0,  32'h0,   0); // 30 WAIT
    v(0, 0, 0,     0, 0, 0,     1,  0, 32'h30,  1, 32'hD1, 32'h30,  0); // 31 HOLD
    v(0, 0, 0,     0, 0, 0,     0,  1, 32'h34,  0, 32'hD1, 32'h30,  0); // 32 REQ

    reset = 1; rv = 0; raddr = 0; gnt = 0; rvalid = 0; rdata = 0; rdy = 0;
    reset1 = 1; rv1 = 0; raddr1 = 0; gnt1 = 0; rvalid1 = 0; rdata1 = 0; rdy1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;

    foreach (vecs[i]) begin
      vec_t t;
      t = vecs[i];
      checks++;
      if ({req, addr, iv, idata, ipc, fault} ===
          {t.e_req, t.e_addr, t.e_iv, t.e_idata, t.e_ipc, t.e_fault} && fpc === t.e_addr)
        passed++;
      else
        $display("FAIL vec%0d: got req=%b addr=%h iv=%b data=%h pc=%h fpc=%h flt=%b expected req=%b addr=%h iv=%b data=%h pc=%h flt=%b",
                 i, req, addr, iv, idata, ipc, fpc, fault,
                 t.e_req, t.e_addr, t.e_iv, t.e_idata, t.e_ipc, t.e_fault);
      reset = t.rst; rv = t.rv; raddr = t.raddr; gnt = t.gnt;
      rvalid = t.rvalid; rdata = t.rdata; rdy = t.rdy;
      @(negedge clk);
    end

    // PC wrap from FFFF_FFFC to 0 on the second instance.
    reset1 = 0;
    chk("wrap_idle_addr", addr1, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_req", {31'h0, req1}, 32'h1);
    chk("wrap_req_addr", addr1, 32'hFFFF_FFFC);
    gnt1 = 1;
    @(negedge clk);
    gnt1 = 0; rvalid1 = 1; rdata1 = 32'hE0;
    @(negedge clk);
    rvalid1 = 0;
    chk("wrap_hold_valid", {31'h0, iv1}, 32'h1);
    chk("wrap_hold_pc", ipc1, 32'hFFFF_FFFC);
    chk("wrap_hold_data", idata1, 32'hE0);
    rdy1 = 1;
    @(negedge clk);
    rdy1 = 0;
    chk("wrap_next_addr", addr1, 32'h0000_0000);
    chk("wrap_next_req", {31'h0, req1}, 32'h1);
    chk("wrap_no_fault", {31'h0, fault1}, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
